// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection scheduler and its environment.
// The emerg input exists only when EMERGENCY_PREEMPT_EN is defined.
interface intersection_scheduler_if;
    logic       side_sensor;
    logic       ped_req;
`ifdef EMERGENCY_PREEMPT_EN
    logic       emerg;
`endif
    logic       main_r, main_y, main_g;
    logic       side_r, side_y, side_g;
    logic       walk;
    logic [2:0] state_o;

    modport master (
`ifdef EMERGENCY_PREEMPT_EN
        output emerg,
`endif
        output side_sensor, ped_req,
        input  main_r, main_y, main_g, side_r, side_y, side_g, walk, state_o
    );

    modport slave (
`ifdef EMERGENCY_PREEMPT_EN
        input  emerg,
`endif
        input  side_sensor, ped_req,
        output main_r, main_y, main_g, side_r, side_y, side_g, walk, state_o
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-road intersection phase scheduler with latched side/pedestrian requests.
// Optional emergency pre-emption is enabled by defining EMERGENCY_PREEMPT_EN.
module intersection_scheduler #(
    parameter int unsigned TW        = 8,
    parameter int unsigned MAIN_MIN  = 20,
    parameter int unsigned SIDE_MIN  = 8,
    parameter int unsigned SIDE_MAX  = 16,
    parameter int unsigned YEL_T     = 4,
    parameter int unsigned AR_T      = 2,
    parameter int unsigned WALK_T    = 10,
    parameter int unsigned PED_CLR_T = 6
) (
    input logic               clk,
    input logic               rst_n,
    intersection_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        StMainGreen  = 3'd0,
        StMainYellow = 3'd1,
        StAllRedA    = 3'd2,
        StSideGreen  = 3'd3,
        StSideYellow = 3'd4,
        StAllRedB    = 3'd5,
        StPedWalk    = 3'd6,
        StPedClear   = 3'd7
    } state_e;

    localparam logic [TW-1:0] MainLast    = TW'(MAIN_MIN - 1);
    localparam logic [TW-1:0] SideMinLast = TW'(SIDE_MIN - 1);
    localparam logic [TW-1:0] SideMaxLast = TW'(SIDE_MAX - 1);
    localparam logic [TW-1:0] YelLast     = TW'(YEL_T - 1);
    localparam logic [TW-1:0] ArLast      = TW'(AR_T - 1);
    localparam logic [TW-1:0] WalkLast    = TW'(WALK_T - 1);
    localparam logic [TW-1:0] PedClrLast  = TW'(PED_CLR_T - 1);

    // {main_r, main_y, main_g, side_r, side_y, side_g, walk}
    localparam logic [6:0] LampsAllRed = 7'b100_100_0;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          side_pend_q, side_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic [6:0]    lamps_q, lamps_d;
    logic          emerg_act;

`ifdef EMERGENCY_PREEMPT_EN
    assign emerg_act = bus.emerg;
`else
    assign emerg_act = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StMainGreen:
                if (!emerg_act && timer_q >= MainLast && (side_pend_q || ped_pend_q))
                    state_d = StMainYellow;
            StMainYellow: if (timer_q == YelLast) state_d = StAllRedA;
            StAllRedA:
                if (timer_q == ArLast) state_d = side_pend_q ? StSideGreen : StPedWalk;
            StSideGreen:
                if (emerg_act || (timer_q >= SideMinLast && !bus.side_sensor) ||
                    timer_q == SideMaxLast)
                    state_d = StSideYellow;
            StSideYellow: if (timer_q == YelLast) state_d = StAllRedB;
            StAllRedB:
                if (timer_q == ArLast)
                    state_d = (ped_pend_q && !emerg_act) ? StPedWalk : StMainGreen;
            StPedWalk: if (emerg_act || timer_q == WalkLast) state_d = StPedClear;
            StPedClear: if (timer_q == PedClrLast) state_d = StMainGreen;
            default: state_d = StAllRedB;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StMainGreen && timer_q >= MainLast) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // A new request on the serving edge wins over the clear.
    always_comb begin
        side_pend_d = bus.side_sensor |
                      (side_pend_q & ~(state_d == StSideGreen && state_q != StSideGreen));
        ped_pend_d  = bus.ped_req |
                      (ped_pend_q & ~(state_d == StPedWalk && state_q != StPedWalk));
    end

    always_comb begin
        lamps_d = LampsAllRed;
        case (state_d)
            StMainGreen:  lamps_d = 7'b001_100_0;
            StMainYellow: lamps_d = 7'b010_100_0;
            StSideGreen:  lamps_d = 7'b100_001_0;
            StSideYellow: lamps_d = 7'b100_010_0;
            StPedWalk:    lamps_d = 7'b100_100_1;
            default:      lamps_d = LampsAllRed;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAllRedB;
            timer_q     <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            lamps_q     <= LampsAllRed;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            lamps_q     <= lamps_d;
        end
    end

    assign {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g,
            bus.walk} = lamps_q;
    assign bus.state_o = state_q;
endmodule
